// File: rtl/interboard_pkg.sv
// Shared definitions for the inter-board transmit scheduler: message layout,
// the end-of-turn code and the scheduler FSM encoding.
package interboard_pkg;

  localparam int MOVE_DIR_W = 1;
  localparam int BLOCK_X_W  = 5;
  localparam int BLOCK_Y_W  = 3;
  localparam int MSG_TYPE_W = 4;
  localparam int CARD_W     = 6;
  localparam int SEL_LEN_W  = 3;
  localparam int MSG_W      = MOVE_DIR_W + BLOCK_X_W + BLOCK_Y_W + MSG_TYPE_W + CARD_W + SEL_LEN_W;

  localparam logic [MSG_TYPE_W-1:0] MSG_END_TURN = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE,
    ST_ERROR
  } tx_state_t;

  // Packed layout is {move_dir, block_x, block_y, msg_type, card, sel_len}.
  function automatic logic [MSG_TYPE_W-1:0] msg_type_of(input logic [MSG_W-1:0] msg);
    return msg[CARD_W+SEL_LEN_W +: MSG_TYPE_W];
  endfunction

endpackage

// File: rtl/interboard_tx_scheduler_msg_fifo.sv
// Outgoing message queue: power-of-two depth, simultaneous push/pop allowed
// even when full, synchronous flush that wins over a same-cycle push.
module msg_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/interboard_tx_scheduler.sv
// Queues GameControl messages and issues them one at a time to the
// communication top while this board holds the turn, with accept timeout/retry.
module interboard_tx_scheduler
  import interboard_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int ACCEPT_TIMEOUT = 15,
  parameter int MAX_RETRY      = 3,
  parameter bit START_TX       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  gc_en,
  input  logic                  gc_move_dir,
  input  logic [BLOCK_X_W-1:0]  gc_block_x,
  input  logic [BLOCK_Y_W-1:0]  gc_block_y,
  input  logic [MSG_TYPE_W-1:0] gc_msg_type,
  input  logic [CARD_W-1:0]     gc_card,
  input  logic [SEL_LEN_W-1:0]  gc_sel_len,
  input  logic                  inter_ready,
  input  logic                  interboard_en,
  input  logic [MSG_TYPE_W-1:0] interboard_msg_type,
  input  logic                  interboard_rst,
  output logic                  transmit,
  output logic                  ctrl_en,
  output logic                  ctrl_move_dir,
  output logic [BLOCK_X_W-1:0]  ctrl_block_x,
  output logic [BLOCK_Y_W-1:0]  ctrl_block_y,
  output logic [MSG_TYPE_W-1:0] ctrl_msg_type,
  output logic [CARD_W-1:0]     ctrl_card,
  output logic [SEL_LEN_W-1:0]  ctrl_sel_len,
  output logic                  q_full,
  output logic                  q_empty,
  output logic                  overflow,
  output logic                  link_err
);

  localparam int TO_W = (ACCEPT_TIMEOUT > 0) ? $clog2(ACCEPT_TIMEOUT + 1) : 1;
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(ACCEPT_TIMEOUT);
  localparam logic [RT_W-1:0] RT_LIMIT  = RT_W'(MAX_RETRY);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [TO_W-1:0]  to_cnt;
  logic [RT_W-1:0]  retry_cnt;
  logic [MSG_W-1:0] wr_msg;
  logic [MSG_W-1:0] head_msg;
  logic             pop;
  logic             to_clr;
  logic             to_inc;
  logic             retry_inc;
  logic             retry_clr;
  logic             set_err;

  assign wr_msg = {gc_move_dir, gc_block_x, gc_block_y, gc_msg_type, gc_card, gc_sel_len};
  assign {ctrl_move_dir, ctrl_block_x, ctrl_block_y, ctrl_msg_type, ctrl_card, ctrl_sel_len} = head_msg;

  msg_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (interboard_rst),
    .push  (gc_en),
    .pop   (pop),
    .wdata (wr_msg),
    .rdata (head_msg),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    state_next = state;
    ctrl_en    = 1'b0;
    pop        = 1'b0;
    to_clr     = 1'b0;
    to_inc     = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    set_err    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (transmit && !q_empty && inter_ready && !link_err) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        ctrl_en    = 1'b1;
        to_clr     = 1'b1;
        state_next = ST_WAIT_ACCEPT;
      end
      ST_WAIT_ACCEPT: begin
        if (!inter_ready) begin
          state_next = ST_WAIT_DONE;
        end else if (to_cnt == TO_LIMIT) begin
          // Retries exhausted: give up on the link for good.
          if (retry_cnt == RT_LIMIT) begin
            set_err    = 1'b1;
            state_next = ST_ERROR;
          end else begin
            retry_inc  = 1'b1;
            state_next = ST_ISSUE;
          end
        end else begin
          to_inc = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (inter_ready) begin
          pop        = 1'b1;
          retry_clr  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || interboard_rst) begin
      state     <= ST_IDLE;
      to_cnt    <= '0;
      retry_cnt <= '0;
      link_err  <= 1'b0;
      overflow  <= 1'b0;
      transmit  <= START_TX;
    end else begin
      state <= state_next;
      if (to_clr)      to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + TO_W'(1);
      if (retry_clr)      retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + RT_W'(1);
      if (set_err) link_err <= 1'b1;
      overflow <= gc_en && q_full && !pop;
      // Sending END_TURN hands the turn over; the peer's END_TURN hands it back.
      if (pop && (msg_type_of(head_msg) == MSG_END_TURN))
        transmit <= 1'b0;
      else if (!transmit && interboard_en && (interboard_msg_type == MSG_END_TURN))
        transmit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// Directed self-checking bench for interboard_tx_scheduler with a simple
// communication-top responder that drives inter_ready.
module tb_interboard_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       gc_en;
  logic       gc_move_dir;
  logic [4:0] gc_block_x;
  logic [2:0] gc_block_y;
  logic [3:0] gc_msg_type;
  logic [5:0] gc_card;
  logic [2:0] gc_sel_len;
  logic       inter_ready;
  logic       interboard_en;
  logic [3:0] interboard_msg_type;
  logic       interboard_rst;
  logic       transmit;
  logic       ctrl_en;
  logic       ctrl_move_dir;
  logic [4:0] ctrl_block_x;
  logic [2:0] ctrl_block_y;
  logic [3:0] ctrl_msg_type;
  logic [5:0] ctrl_card;
  logic [2:0] ctrl_sel_len;
  logic       q_full;
  logic       q_empty;
  logic       overflow;
  logic       link_err;

  int checks = 0;
  int errors = 0;

  logic [3:0] logType [64];
  int         logCycle [64];
  int         issueTotal = 0;
  int         cycleCount = 0;

  int acceptDelay = 2;
  int doneDelay   = 4;
  bit stuckReady  = 1'b0;

  interboard_tx_scheduler dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .gc_en               (gc_en),
    .gc_move_dir         (gc_move_dir),
    .gc_block_x          (gc_block_x),
    .gc_block_y          (gc_block_y),
    .gc_msg_type         (gc_msg_type),
    .gc_card             (gc_card),
    .gc_sel_len          (gc_sel_len),
    .inter_ready         (inter_ready),
    .interboard_en       (interboard_en),
    .interboard_msg_type (interboard_msg_type),
    .interboard_rst      (interboard_rst),
    .transmit            (transmit),
    .ctrl_en             (ctrl_en),
    .ctrl_move_dir       (ctrl_move_dir),
    .ctrl_block_x        (ctrl_block_x),
    .ctrl_block_y        (ctrl_block_y),
    .ctrl_msg_type       (ctrl_msg_type),
    .ctrl_card           (ctrl_card),
    .ctrl_sel_len        (ctrl_sel_len),
    .q_full              (q_full),
    .q_empty             (q_empty),
    .overflow            (overflow),
    .link_err            (link_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Record every issue with its cycle number for order and spacing checks.
  initial begin
    forever begin
      @(negedge clk);
      if (ctrl_en) begin
        if (issueTotal < 64) begin
          logType[issueTotal]  = ctrl_msg_type;
          logCycle[issueTotal] = cycleCount;
        end
        issueTotal = issueTotal + 1;
      end
    end
  end

  // Communication-top model: busy acceptDelay cycles after ctrl_en, idle doneDelay later.
  initial begin
    inter_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (ctrl_en && !stuckReady) begin
        repeat (acceptDelay) @(negedge clk);
        inter_ready = 1'b0;
        repeat (doneDelay) @(negedge clk);
        inter_ready = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [21:0] packMsg(input logic [3:0] mt, input logic [4:0] bx);
    logic [5:0] card;
    card = {2'b10, mt};
    return {bx[0], bx, mt[2:0], mt, card, bx[2:0]};
  endfunction

  task automatic applyStimulus(input logic [3:0] mt, input logic [4:0] bx);
    {gc_move_dir, gc_block_x, gc_block_y, gc_msg_type, gc_card, gc_sel_len} = packMsg(mt, bx);
    gc_en = 1'b1;
    tick();
    gc_en = 1'b0;
  endtask

  task automatic peerMsg(input logic [3:0] t);
    interboard_en       = 1'b1;
    interboard_msg_type = t;
    tick();
    interboard_en       = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic waitEmpty(input string tag, input int budget);
    int n = 0;
    while (!(q_empty && inter_ready) && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(q_empty && inter_ready), 32'd1);
  endtask

  task automatic waitReady(input string tag, input logic level, input int budget);
    int n = 0;
    while (inter_ready !== level && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(inter_ready), 32'(level));
  endtask

  initial begin
    int base;
    int n;
    logic [3:0] expOrder [5];

    rst_n               = 1'b0;
    gc_en               = 1'b0;
    gc_move_dir         = 1'b0;
    gc_block_x          = '0;
    gc_block_y          = '0;
    gc_msg_type         = '0;
    gc_card             = '0;
    gc_sel_len          = '0;
    interboard_en       = 1'b0;
    interboard_msg_type = '0;
    interboard_rst      = 1'b0;
    tick();
    tick();
    checkOutput("rst_q_empty", 32'(q_empty), 32'd1);
    checkOutput("rst_q_full", 32'(q_full), 32'd0);
    checkOutput("rst_ctrl_en", 32'(ctrl_en), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_link_err", 32'(link_err), 32'd0);
    checkOutput("rst_transmit", 32'(transmit), 32'd1);
    rst_n = 1'b1;
    tick();

    // Basic issue: latency, head fields, order 1,2,3.
    base = issueTotal;
    applyStimulus(4'd1, 5'd3);
    checkOutput("lat_cycle1_no_en", 32'(ctrl_en), 32'd0);
    checkOutput("head_fields", 32'({ctrl_move_dir, ctrl_block_x, ctrl_block_y, ctrl_msg_type, ctrl_card, ctrl_sel_len}),
                32'(packMsg(4'd1, 5'd3)));
    tick();
    checkOutput("lat_cycle2_en", 32'(ctrl_en), 32'd1);
    applyStimulus(4'd2, 5'd10);
    applyStimulus(4'd3, 5'd21);
    waitEmpty("t1_drain", 200);
    repeat (5) tick();
    checkOutput("t1_issue_count", 32'(issueTotal - base), 32'd3);
    for (int i = 0; i < 3; i++) checkOutput("t1_order", 32'(logType[base+i]), 32'(i + 1));
    checkOutput("t1_q_empty", 32'(q_empty), 32'd1);

    // END_TURN hand-over, overflow while not transmitting, peer hands turn back.
    base = issueTotal;
    applyStimulus(4'hF, 5'd1);
    applyStimulus(4'd6, 5'd2);
    applyStimulus(4'd7, 5'd4);
    applyStimulus(4'd8, 5'd6);
    n = 0;
    while (ctrl_msg_type == 4'hF && n < 100) begin
      tick();
      n++;
    end
    checkOutput("tx_fall_on_pop", 32'(transmit), 32'd0);
    checkOutput("head_after_end", 32'(ctrl_msg_type), 32'd6);
    checkOutput("t2_not_full_3", 32'(q_full), 32'd0);
    applyStimulus(4'd9, 5'd8);
    checkOutput("full_at_4", 32'(q_full), 32'd1);
    checkOutput("no_ovf_at_4", 32'(overflow), 32'd0);
    applyStimulus(4'd10, 5'd9);
    checkOutput("ovf_pulse", 32'(overflow), 32'd1);
    tick();
    checkOutput("ovf_one_cycle", 32'(overflow), 32'd0);
    checkOutput("still_full", 32'(q_full), 32'd1);
    repeat (20) tick();
    checkOutput("held_while_not_tx", 32'(issueTotal - base), 32'd1);
    peerMsg(4'd3);
    checkOutput("non_end_ignored", 32'(transmit), 32'd0);
    peerMsg(4'hF);
    checkOutput("peer_end_sets_tx", 32'(transmit), 32'd1);
    waitEmpty("t2_drain", 300);
    repeat (5) tick();
    checkOutput("t2_issue_count", 32'(issueTotal - base), 32'd5);
    expOrder = '{4'hF, 4'd6, 4'd7, 4'd8, 4'd9};
    for (int i = 0; i < 5; i++) checkOutput("t2_order", 32'(logType[base+i]), 32'(expOrder[i]));

    // Push into a full queue in the same cycle as a pop.
    doReset();
    doneDelay = 10;
    base = issueTotal;
    applyStimulus(4'd1, 5'd1);
    applyStimulus(4'd2, 5'd2);
    applyStimulus(4'd3, 5'd3);
    applyStimulus(4'd4, 5'd4);
    waitReady("t3_busy", 1'b0, 50);
    waitReady("t3_done", 1'b1, 50);
    checkOutput("full_before_pop", 32'(q_full), 32'd1);
    applyStimulus(4'd5, 5'd5);
    checkOutput("no_ovf_on_pop", 32'(overflow), 32'd0);
    checkOutput("full_after_swap", 32'(q_full), 32'd1);
    waitEmpty("t3_drain", 400);
    repeat (5) tick();
    checkOutput("t3_issue_count", 32'(issueTotal - base), 32'd5);
    for (int i = 0; i < 5; i++) checkOutput("t3_order", 32'(logType[base+i]), 32'(i + 1));
    doneDelay = 4;

    // Accept timeout with retries, then terminal error.
    doReset();
    stuckReady = 1'b1;
    base = issueTotal;
    applyStimulus(4'd2, 5'd7);
    n = 0;
    while (!link_err && n < 150) begin
      tick();
      n++;
    end
    checkOutput("link_err_set", 32'(link_err), 32'd1);
    checkOutput("retry_issue_count", 32'(issueTotal - base), 32'd4);
    for (int i = 1; i < 4; i++)
      checkOutput("retry_spacing", 32'(logCycle[base+i] - logCycle[base+i-1]), 32'd17);
    repeat (40) tick();
    checkOutput("no_issue_in_error", 32'(issueTotal - base), 32'd4);
    checkOutput("link_err_sticky", 32'(link_err), 32'd1);
    applyStimulus(4'd3, 5'd1);
    applyStimulus(4'd4, 5'd2);
    applyStimulus(4'd5, 5'd3);
    checkOutput("enq_in_error", 32'(q_full), 32'd1);
    interboard_rst = 1'b1;
    tick();
    interboard_rst = 1'b0;
    checkOutput("irst_clears_err", 32'(link_err), 32'd0);
    checkOutput("irst_empties", 32'(q_empty), 32'd1);
    stuckReady = 1'b0;
    repeat (3) tick();

    // Peer reset mid-transaction beats a same-cycle enqueue and END_TURN.
    doneDelay = 30;
    base = issueTotal;
    applyStimulus(4'd1, 5'd1);
    applyStimulus(4'd2, 5'd2);
    applyStimulus(4'd3, 5'd3);
    waitReady("t5_busy", 1'b0, 50);
    tick();
    tick();
    {gc_move_dir, gc_block_x, gc_block_y, gc_msg_type, gc_card, gc_sel_len} = packMsg(4'd4, 5'd4);
    gc_en               = 1'b1;
    interboard_en       = 1'b1;
    interboard_msg_type = 4'hF;
    interboard_rst      = 1'b1;
    tick();
    gc_en          = 1'b0;
    interboard_en  = 1'b0;
    interboard_rst = 1'b0;
    checkOutput("irst_q_empty", 32'(q_empty), 32'd1);
    checkOutput("irst_q_full", 32'(q_full), 32'd0);
    checkOutput("irst_transmit", 32'(transmit), 32'd1);
    checkOutput("irst_ctrl_en", 32'(ctrl_en), 32'd0);
    repeat (60) tick();
    checkOutput("no_issue_after_irst", 32'(issueTotal - base), 32'd1);
    checkOutput("irst_stays_empty", 32'(q_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
